mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Second bus initiator for the unified memory port, next to the risc_v core: memory_ra / memory_rd / memory_wa / memory_wd / memory_wen / memory_func3.
- Copies a block of 32-bit words from a source address to a destination address, one word at a time, using word-size accesses.
- Used for program relocation and LED/RGB pattern buffers.
- Bus arbitration with the core is handled outside this block; this block assumes it owns the port whenever busy=1.

Parameters:
- READ_LATENCY, 1: cycles from memory_ra being presented to memory_rd being valid (synchronous BRAM read). Legal range 1..4.
- COUNT_WIDTH, 16: width of word_count and of the internal remaining-words counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr  input  32  destination byte address; bits [1:0] ignored.
- word_count  input  COUNT_WIDTH  number of words to copy; 0 is legal.
- busy  output  1  high from the cycle after start is accepted until the cycle DONE is entered.
- done  output  1  one-cycle pulse when the copy completes.
- memory_ra  output  32  read address to memory.
- memory_rd  input  32  read data from memory, valid READ_LATENCY cycles after memory_ra.
- memory_wa  output  32  write address to memory.
- memory_wd  output  32  write data to memory.
- memory_wen  output  1  write enable; at most one cycle per copied word.
- memory_func3  output  3  access size; constant 3'b010 (word).

Behaviour:
- Reset values: busy=0, done=0, memory_wen=0, memory_ra=0, memory_wa=0, memory_wd=0, memory_func3=3'b010. FSM resets to IDLE.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE
  - start=1 latches src={src_addr[31:2],2'b00}, dst={dst_addr[31:2],2'b00}, remaining=word_count.
  - If word_count=0, go to DONE; otherwise go to READ.
  - start while not in IDLE is ignored; there is no queueing.
- READ
  - memory_ra=src for exactly this cycle.
  - Load the latency counter with READ_LATENCY-1, then go to WAIT.
- WAIT
  - Stay while the latency counter is nonzero, decrementing it each cycle.
  - In the cycle the counter is 0, capture memory_rd into the data register, then go to WRITE.
  - With READ_LATENCY=1, WAIT lasts exactly 1 cycle.
- WRITE
  - memory_wen=1, memory_wa=dst, memory_wd=data register, all for one cycle.
  - At the same clock edge: src+=4, dst+=4, remaining-=1.
  - Go to DONE if remaining was 1, else go to READ.
- DONE
  - done=1 for one cycle, busy=0, then go to IDLE.
  - A start in DONE is ignored.
- Throughput and latency:
  - READ_LATENCY+2 cycles per word.
  - N words with N>0: the first READ is the cycle after start; done is asserted N*(READ_LATENCY+2)+1 cycles after the start cycle.
  - N=0: done is asserted the cycle after start, with no memory access.
- Addresses wrap modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000); no error is flagged.
- Overlapping regions are copied strictly in ascending order, word by word. When dst>src and the regions overlap, the result is the defined forward-copy smear; this is not an error.
- memory_ra holds its last value outside READ. memory_wa and memory_wd hold their last values while memory_wen=0.
- Reset mid-copy: FSM returns to IDLE at that edge. The next cycle has memory_wen=0, busy=0, done=0. A partial copy stays in memory.
- reset and start in the same cycle: reset wins and start is dropped.

Test Plan:
- Preload words 0x11111111, 0x22222222, 0x33333333 at 0x100, 0x104, 0x108. Start with src=0x100, dst=0x200, count=3, READ_LATENCY=1 -> exactly three memory_wen pulses at wa 0x200, 0x204, 0x208 with matching wd; done 10 cycles after start; busy for 9 cycles.
- count=0 with src=0x100 -> done the cycle after start; memory_wen never asserted; memory_ra unchanged.
- src=0x103, dst=0x201 -> accesses use 0x100 and 0x200; memory_func3=3'b010 throughout.
- Overlap: src=0x100, dst=0x104, count=2 with 0xA, 0xB preloaded -> memory holds 0xA at 0x104 and 0xA at 0x108.
- Assert reset in the second WRITE of a 4-word copy -> memory_wen=0 from the next cycle; only 2 words written; no done pulse. A new start then completes normally.
- READ_LATENCY=3, count=2 -> wd captured 3 cycles after each ra; done 11 cycles after start. start pulses while busy are ignored.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-by-word block copy initiator for the unified memory port.
// Walks READ -> WAIT (READ_LATENCY cycles) -> WRITE per word, ascending addresses.
module mem_copy_engine #(
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            memory_ra,
  input  logic [31:0]            memory_rd,
  output logic [31:0]            memory_wa,
  output logic [31:0]            memory_wd,
  output logic                   memory_wen,
  output logic [2:0]             memory_func3
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e                 state_q, state_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [2:0]             lat_q, lat_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            ra_q, ra_d;
  logic [31:0]            wa_q, wa_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      ra_q    <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      ra_q    <= ra_d;
      wa_q    <= wa_d;
    end
  end

  // ra/wa are loaded on entry to READ/WRITE so they are valid in those cycles
  // and hold their last value otherwise.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    data_d  = data_q;
    ra_d    = ra_q;
    wa_d    = wa_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr & WORD_MASK;
          dst_d = dst_addr & WORD_MASK;
          rem_d = word_count;
          if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            ra_d    = src_addr & WORD_MASK;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        lat_d   = 3'(READ_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 3'd1;
        end else begin
          data_d  = memory_rd;
          wa_d    = dst_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        src_d = src_q + 32'd4;
        dst_d = dst_q + 32'd4;
        rem_d = rem_q - COUNT_WIDTH'(1);
        if (rem_q == COUNT_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          ra_d    = src_q + 32'd4;
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign memory_wen   = (state_q == S_WRITE);
  assign memory_ra    = ra_q;
  assign memory_wa    = wa_q;
  assign memory_wd    = data_q;
  assign memory_func3 = 3'b010;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: two instances (READ_LATENCY 1 and 3), each with a
// latency-pipelined memory and a cycle-accurate transaction-level expectation.
module tb_mem_copy_engine;

  int checks = 0;
  int errors = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit fin [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Hand-derived timing: done at N*(RL+2)+1 cycles after start, busy for N*(RL+2).
  localparam int EXP_D3 [2] = '{10, 16};
  localparam int EXP_B3 [2] = '{9, 15};
  localparam int EXP_D2 [2] = '{7, 11};
  localparam int EXP_D4 [2] = '{13, 21};

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int RL = (g == 0) ? 1 : 3;
    localparam int P  = RL + 2;

    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, wen;
    logic [31:0] ra, rd, wa, wd;
    logic [2:0]  f3;

    mem_copy_engine #(.READ_LATENCY(RL), .COUNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .word_count(word_count), .busy(busy), .done(done),
      .memory_ra(ra), .memory_rd(rd), .memory_wa(wa), .memory_wd(wd),
      .memory_wen(wen), .memory_func3(f3)
    );

    logic [31:0] mem [4096];
    logic [31:0] mdl [4096];
    logic [31:0] pipe [RL];

    always @(posedge clk) begin
      if (wen === 1'b1) mem[wa[13:2]] <= wd;
      pipe[0] <= mem[ra[13:2]];
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign rd = pipe[RL-1];

    int          t0 = 0, n = 0, abort_c = -1;
    logic [31:0] jsrc = '0, jdst = '0;
    bit          jvalid = 1'b0, chk_en = 1'b0, rst_edge = 1'b0;
    logic [31:0] e_ra = '0, e_wa = '0, e_wd = '0, e_data = '0;
    int          wen_cnt = 0, done_cnt = 0, busy_cnt = 0, done_rel = -1;

    always @(posedge clk) rst_edge <= reset;

    always @(negedge clk) begin : compare
      int rel, ph, w;
      bit alive, eb, ed, ew;
      if (chk_en) begin
        rel = cyc - t0;
        eb = 1'b0; ed = 1'b0; ew = 1'b0;
        if (rst_edge) begin
          e_ra = '0; e_wa = '0; e_wd = '0;
        end
        alive = jvalid && !(abort_c >= t0 && abort_c < cyc);
        if (alive && rel >= 1) begin
          if (n == 0) begin
            ed = (rel == 1);
          end else begin
            eb = (rel <= n * P);
            ed = (rel == n * P + 1);
            if (eb) begin
              ph = (rel - 1) % P;
              w  = (rel - 1) / P;
              if (ph == 0) begin
                e_ra   = jsrc + 32'(4 * w);
                e_data = mdl[e_ra[13:2]];
              end
              if (ph == P - 1) begin
                ew   = 1'b1;
                e_wa = jdst + 32'(4 * w);
                e_wd = e_data;
                mdl[e_wa[13:2]] = e_wd;
              end
            end
          end
        end
        chk($sformatf("rl%0d busy", RL), 32'(busy), 32'(eb));
        chk($sformatf("rl%0d done", RL), 32'(done), 32'(ed));
        chk($sformatf("rl%0d wen", RL), 32'(wen), 32'(ew));
        chk($sformatf("rl%0d func3", RL), 32'(f3), 32'd2);
        chk($sformatf("rl%0d ra", RL), ra, e_ra);
        chk($sformatf("rl%0d wa", RL), wa, e_wa);
        chk($sformatf("rl%0d wd", RL), wd, e_wd);
        if (wen === 1'b1) wen_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
          done_cnt++;
          done_rel = rel;
        end
      end
    end

    task automatic pre(input logic [31:0] a, input logic [31:0] v);
      mem[a[13:2]] = v;
      mdl[a[13:2]] = v;
    endtask

    function automatic logic [31:0] rdm(input logic [31:0] a);
      return mem[a[13:2]];
    endfunction

    // abort_rel: cycle (relative to start) in which reset is raised, -1 none.
    // ign: cycle with an extra start pulse while busy (plus one in DONE), 0 none.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int nn,
                       input int abort_rel, input int ign);
      int len;
      @(negedge clk);
      wen_cnt = 0; done_cnt = 0; busy_cnt = 0; done_rel = -1;
      src_addr = s; dst_addr = d; word_count = 16'(nn); start = 1'b1;
      t0 = cyc; n = nn;
      jsrc = s & 32'hFFFF_FFFC;
      jdst = d & 32'hFFFF_FFFC;
      abort_c = (abort_rel < 0) ? -1 : cyc + abort_rel;
      jvalid = 1'b1;
      reset = (abort_rel == 0);
      len = (nn == 0) ? 1 : nn * P + 1;
      for (int k = 1; k <= len + 3; k++) begin
        @(negedge clk);
        start = (ign > 0) && (k == ign || k == len);
        if (start) begin
          src_addr   = $urandom;
          dst_addr   = $urandom;
          word_count = 16'($urandom_range(1, 5));
        end
        reset = (abort_rel > 0) && (k == abort_rel);
      end
      start = 1'b0;
      reset = 1'b0;
    endtask

    initial begin : stim
      int bad, nn, ign;
      logic [31:0] s, d;
      for (int i = 0; i < 4096; i++) begin
        mem[i] = $urandom;
        mdl[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      chk($sformatf("rl%0d rst busy", RL), 32'(busy), 32'd0);
      chk($sformatf("rl%0d rst done", RL), 32'(done), 32'd0);
      chk($sformatf("rl%0d rst wen", RL), 32'(wen), 32'd0);
      chk($sformatf("rl%0d rst ra", RL), ra, 32'd0);
      chk($sformatf("rl%0d rst wa", RL), wa, 32'd0);
      chk($sformatf("rl%0d rst wd", RL), wd, 32'd0);
      chk($sformatf("rl%0d rst func3", RL), 32'(f3), 32'd2);
      reset = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;

      pre(32'h100, 32'h1111_1111);
      pre(32'h104, 32'h2222_2222);
      pre(32'h108, 32'h3333_3333);
      run(32'h100, 32'h200, 3, -1, 0);
      chk($sformatf("rl%0d t1 wen pulses", RL), 32'(wen_cnt), 32'd3);
      chk($sformatf("rl%0d t1 done cycle", RL), 32'(done_rel), 32'(EXP_D3[g]));
      chk($sformatf("rl%0d t1 busy cycles", RL), 32'(busy_cnt), 32'(EXP_B3[g]));
      chk($sformatf("rl%0d t1 mem 200", RL), rdm(32'h200), 32'h1111_1111);
      chk($sformatf("rl%0d t1 mem 204", RL), rdm(32'h204), 32'h2222_2222);
      chk($sformatf("rl%0d t1 mem 208", RL), rdm(32'h208), 32'h3333_3333);

      run(32'h100, 32'h300, 0, -1, 0);
      chk($sformatf("rl%0d zero wen", RL), 32'(wen_cnt), 32'd0);
      chk($sformatf("rl%0d zero done cycle", RL), 32'(done_rel), 32'd1);
      chk($sformatf("rl%0d zero ra held", RL), ra, 32'h108);

      pre(32'h100, 32'hCAFE_F00D);
      run(32'h103, 32'h201, 1, -1, 0);
      chk($sformatf("rl%0d unaligned mem 200", RL), rdm(32'h200), 32'hCAFE_F00D);

      pre(32'h100, 32'hA);
      pre(32'h104, 32'hB);
      run(32'h100, 32'h104, 2, -1, 0);
      chk($sformatf("rl%0d overlap mem 104", RL), rdm(32'h104), 32'hA);
      chk($sformatf("rl%0d overlap mem 108", RL), rdm(32'h108), 32'hA);
      chk($sformatf("rl%0d overlap done cycle", RL), 32'(done_rel), 32'(EXP_D2[g]));

      pre(32'h508, 32'h5A5A_5A5A);
      run(32'h400, 32'h500, 4, 2 * P, 0);
      chk($sformatf("rl%0d abort wen pulses", RL), 32'(wen_cnt), 32'd2);
      chk($sformatf("rl%0d abort done pulses", RL), 32'(done_cnt), 32'd0);
      chk($sformatf("rl%0d abort mem 508", RL), rdm(32'h508), 32'h5A5A_5A5A);

      run(32'h400, 32'h600, 4, -1, 3);
      chk($sformatf("rl%0d after abort done cycle", RL), 32'(done_rel), 32'(EXP_D4[g]));
      chk($sformatf("rl%0d after abort wen pulses", RL), 32'(wen_cnt), 32'd4);
      chk($sformatf("rl%0d after abort done pulses", RL), 32'(done_cnt), 32'd1);

      run(32'h100, 32'h700, 2, 0, 0);
      chk($sformatf("rl%0d rst+start wen", RL), 32'(wen_cnt), 32'd0);
      chk($sformatf("rl%0d rst+start done", RL), 32'(done_cnt), 32'd0);

      run(32'hFFFF_FFF8, 32'h800, 4, -1, 0);
      run(32'h900, 32'hFFFF_FFFC, 2, -1, 0);
      chk($sformatf("rl%0d wrap wa", RL), wa, 32'h0);

      repeat (12) begin
        s   = 32'h1000 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
        d   = 32'h1000 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
        nn  = $urandom_range(0, 6);
        ign = (nn > 0) ? $urandom_range(1, nn * P) : 0;
        run(s, d, nn, -1, ign);
      end

      bad = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== mdl[i]) bad++;
      chk($sformatf("rl%0d memory image", RL), 32'(bad), 32'd0);
      fin[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 50000 && !(fin[0] && fin[1]); i++) @(posedge clk);
    if (!(fin[0] && fin[1])) begin
      checks++;
      errors++;
      $display("FAIL timeout: got unfinished expected finished");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
